// File: rtl/encoder_sim_gen.sv
// Quadrature encoder generator: emits A/B steps at a programmable rate for a fixed or open-ended count.
// Optional index (Z) output is compiled in only when ENCODER_GEN_INDEX_EN is defined.
module encoder_sim_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_gen_start,
    input  logic        reg_gen_stop,
    input  logic        reg_gen_dir,
    input  logic [31:0] reg_gen_step_div,
    input  logic [31:0] reg_gen_step_num,
    input  logic        reg_gen_clr,
    input  logic [31:0] reg_gen_index_div,
    output logic        encoder_a_out,
    output logic        encoder_b_out,
    output logic        encoder_z_out,
    output logic        reg_gen_busy,
    output logic        reg_gen_done,
    output logic [31:0] reg_gen_location
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state;
    logic        dir_q;
    logic [31:0] div_q;
    logic [31:0] num_q;
    logic [31:0] div_cnt;
    logic [31:0] step_cnt;
    logic [1:0]  phase;
    logic [1:0]  next_phase;
    logic        start_ok;
    logic        step;

    assign start_ok     = (state == IDLE) && reg_gen_start && !reg_gen_stop;
    assign step         = (state == RUN) && !reg_gen_stop && (div_cnt == div_q - 32'd1);
    assign next_phase   = dir_q ? phase - 2'd1 : phase + 2'd1;
    assign reg_gen_busy = (state == RUN);

    // NOTE: every register uses non-blocking assignment so all updates see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            dir_q            <= 1'b0;
            div_q            <= 32'd1;
            num_q            <= 32'd0;
            div_cnt          <= 32'd0;
            step_cnt         <= 32'd0;
            phase            <= 2'd0;
            encoder_a_out    <= 1'b0;
            encoder_b_out    <= 1'b0;
            reg_gen_done     <= 1'b0;
            reg_gen_location <= 32'd0;
        end else begin
            reg_gen_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        dir_q    <= reg_gen_dir;
                        div_q    <= (reg_gen_step_div == 32'd0) ? 32'd1 : reg_gen_step_div;
                        num_q    <= reg_gen_step_num;
                        div_cnt  <= 32'd0;
                        step_cnt <= 32'd0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (reg_gen_stop) begin
                        state <= IDLE;
                    end else if (step) begin
                        div_cnt       <= 32'd0;
                        step_cnt      <= step_cnt + 32'd1;
                        phase         <= next_phase;
                        // Gray mapping: p1 and p2 have A high, p2 and p3 have B high.
                        encoder_a_out <= next_phase[1] ^ next_phase[0];
                        encoder_b_out <= next_phase[1];
                        if ((num_q != 32'd0) && (step_cnt == num_q - 32'd1)) begin
                            state        <= IDLE;
                            reg_gen_done <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (reg_gen_clr) begin
                reg_gen_location <= 32'd0;
            end else if (step) begin
                reg_gen_location <= reg_gen_location + (dir_q ? 32'hFFFF_FFFF : 32'd1);
            end
        end
    end

`ifdef ENCODER_GEN_INDEX_EN
    logic [31:0] index_div_q;
    logic [31:0] index_cnt;

    // Z rises on every index_div-th entry into p0 and falls when the phase leaves p0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_div_q   <= 32'd0;
            index_cnt     <= 32'd0;
            encoder_z_out <= 1'b0;
        end else begin
            if (start_ok) begin
                index_div_q <= reg_gen_index_div;
            end
            if (step) begin
                if (next_phase == 2'd0) begin
                    if ((index_div_q != 32'd0) && (index_cnt >= index_div_q - 32'd1)) begin
                        index_cnt     <= 32'd0;
                        encoder_z_out <= 1'b1;
                    end else begin
                        index_cnt     <= index_cnt + 32'd1;
                        encoder_z_out <= 1'b0;
                    end
                end else begin
                    encoder_z_out <= 1'b0;
                end
            end
        end
    end
`else
    logic unused_index_div;

    assign unused_index_div = ^reg_gen_index_div;
    assign encoder_z_out    = 1'b0;
`endif

endmodule
